// File: rtl/tlp_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlp_tx_arbiter_pkg
// Description : Shared field widths, arbiter state encoding and the
//               TLP-length-to-beat-count helper for the TX TLP arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package tlp_tx_arbiter_pkg;

    localparam int C_FMT_W   = 7;
    localparam int C_LEN_W   = 10;
    localparam int C_TID_W   = 24;
    localparam int C_BC_W    = 13;
    localparam int C_LADDR_W = 7;
    localparam int C_ADDR_W  = 64;
    localparam int C_BE_W    = 8;
    localparam int C_ATTR_W  = 2;
    // 512 beats is the largest TLP (1024 DW at 2 DW per beat)
    localparam int C_BEATS_W = 10;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_GRANT = 2'd1;
    localparam logic [1:0] C_ST_XFER  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = C_ST_IDLE,
        GRANT = C_ST_GRANT,
        XFER  = C_ST_XFER
    } arb_state_e;

    // Beats needed on a 2-DW bus. Header-only TLPs (fmt bit 6 clear) still
    // occupy one beat; a length field of 0 encodes 1024 DW.
    function automatic logic [C_BEATS_W-1:0] len_to_beats(
        input logic [C_FMT_W-1:0] fmt_type,
        input logic [C_LEN_W-1:0] len
    );
        logic [C_LEN_W:0] w_len;
        if (!fmt_type[6]) begin
            return C_BEATS_W'(1);
        end
        w_len = (len == '0) ? 11'd1024 : {1'b0, len};
        return C_BEATS_W'((w_len + 11'd1) >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlp_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : tlp_rr_picker
// Description : Combinational round-robin priority encoder. The search for a
//               requester starts at (i_last_winner + 1) mod NUMB_MASTER.
// Ports       : i_req          - request vector
//               i_last_winner  - index of the previous winner
//               o_grant_onehot - one-hot selected requester
//               o_grant_idx    - index of the selected requester
//               o_any_req      - at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module tlp_rr_picker #(
    parameter int NUMB_MASTER = 2,
    parameter int IDX_W       = (NUMB_MASTER > 1) ? $clog2(NUMB_MASTER) : 1
) (
    input  logic [NUMB_MASTER-1:0] i_req,
    input  logic [IDX_W-1:0]       i_last_winner,
    output logic [NUMB_MASTER-1:0] o_grant_onehot,
    output logic [IDX_W-1:0]       o_grant_idx,
    output logic                   o_any_req
);

    logic [IDX_W-1:0] w_cand;

    // Walk the rotated order from lowest priority to highest so the last
    // hit written is the highest-priority requester.
    always_comb begin
        o_grant_onehot = '0;
        o_grant_idx    = '0;
        o_any_req      = |i_req;
        w_cand         = '0;
        for (int i = NUMB_MASTER - 1; i >= 0; i--) begin
            w_cand = IDX_W'((int'(i_last_winner) + 1 + i) % NUMB_MASTER);
            if (i_req[w_cand]) begin
                o_grant_onehot         = '0;
                o_grant_onehot[w_cand] = 1'b1;
                o_grant_idx            = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tlp_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tlp_tx_arbiter
// Description : Round-robin arbiter between NUMB_MASTER TLP masters. The
//               winner's header is latched onto tx_* and its data beats are
//               passed combinationally onto one TX stream with SOF/EOF
//               framing. Grant is held until the last beat is accepted.
// Ports       : axi_clk / axi_reset_n (async, active-low)
//               cfg_bus_mast_en          - gates new grants
//               tlp_*  (per master)      - request/grant, header, data, flow ctl
//               tx_*                     - muxed TX TLP stream, active-low ctl
//               stat_pkt_cnt             - per-master completed TLP count
//                                          (only with TLP_TX_ARBITER_STATS_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module tlp_tx_arbiter
    import tlp_tx_arbiter_pkg::*;
#(
    parameter int NUMB_MASTER = 2,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                             axi_clk,
    input  logic                             axi_reset_n,
    input  logic                             cfg_bus_mast_en,
    input  logic [NUMB_MASTER-1:0]           tlp_req_to_send,
    output logic [NUMB_MASTER-1:0]           tlp_grant,
    input  logic [NUMB_MASTER*C_FMT_W-1:0]   tlp_fmt_type,
    input  logic [NUMB_MASTER*C_LEN_W-1:0]   tlp_length_in_dw,
    input  logic [NUMB_MASTER-1:0]           tlp_src_rdy_n,
    output logic [NUMB_MASTER-1:0]           tlp_dst_rdy_n,
    input  logic [NUMB_MASTER*DATA_WIDTH-1:0] tlp_data,
    input  logic [NUMB_MASTER*C_ADDR_W-1:0]  tlp_address,
    input  logic [NUMB_MASTER*C_BE_W-1:0]    tlp_ldwbe_fdwbe,
    input  logic [NUMB_MASTER*C_ATTR_W-1:0]  tlp_attr,
    input  logic [NUMB_MASTER*C_TID_W-1:0]   tlp_transaction_id,
    input  logic [NUMB_MASTER*C_BC_W-1:0]    tlp_byte_count,
    input  logic [NUMB_MASTER*C_LADDR_W-1:0] tlp_lower_address,
    output logic [C_FMT_W-1:0]               tx_fmt_type,
    output logic [C_LEN_W-1:0]               tx_length_in_dw,
    output logic [C_ADDR_W-1:0]              tx_address,
    output logic [C_BE_W-1:0]                tx_ldwbe_fdwbe,
    output logic [C_ATTR_W-1:0]              tx_attr,
    output logic [C_TID_W-1:0]               tx_transaction_id,
    output logic [C_BC_W-1:0]                tx_byte_count,
    output logic [C_LADDR_W-1:0]             tx_lower_address,
    output logic [DATA_WIDTH-1:0]            tx_data,
    output logic                             tx_sof_n,
    output logic                             tx_eof_n,
    output logic                             tx_src_rdy_n,
    input  logic                             tx_dst_rdy_n
`ifdef TLP_TX_ARBITER_STATS_EN
    ,
    output logic [NUMB_MASTER*32-1:0]        stat_pkt_cnt
`endif
);

    localparam int IDX_W = $clog2(NUMB_MASTER);

    arb_state_e              r_state;
    logic [NUMB_MASTER-1:0]  r_grant;
    logic [IDX_W-1:0]        r_winner;
    logic [IDX_W-1:0]        r_last_winner;
    logic [C_BEATS_W-1:0]    r_beats_left;
    logic                    r_sof_pending;
    logic                    r_hdr_only;
    logic [C_FMT_W-1:0]      r_fmt_type;
    logic [C_LEN_W-1:0]      r_length_in_dw;
    logic [C_ADDR_W-1:0]     r_address;
    logic [C_BE_W-1:0]       r_ldwbe_fdwbe;
    logic [C_ATTR_W-1:0]     r_attr;
    logic [C_TID_W-1:0]      r_transaction_id;
    logic [C_BC_W-1:0]       r_byte_count;
    logic [C_LADDR_W-1:0]    r_lower_address;

    logic [NUMB_MASTER-1:0]  w_pick_onehot;
    logic [IDX_W-1:0]        w_pick_idx;
    logic                    w_any_req;
    logic                    w_xfer;
    logic                    w_accept;
    logic                    w_last;
    logic [C_FMT_W-1:0]      w_sel_fmt;
    logic [C_LEN_W-1:0]      w_sel_len;
    int                      w_wi;

    tlp_rr_picker #(
        .NUMB_MASTER (NUMB_MASTER),
        .IDX_W       (IDX_W)
    ) u_picker (
        .i_req          (tlp_req_to_send),
        .i_last_winner  (r_last_winner),
        .o_grant_onehot (w_pick_onehot),
        .o_grant_idx    (w_pick_idx),
        .o_any_req      (w_any_req)
    );

    assign w_wi      = int'(r_winner);
    assign w_sel_fmt = tlp_fmt_type[w_wi*C_FMT_W +: C_FMT_W];
    assign w_sel_len = tlp_length_in_dw[w_wi*C_LEN_W +: C_LEN_W];

    // Data path is purely combinational during XFER; header-only TLPs do not
    // wait on the master's src_rdy since there is no payload to supply.
    assign w_xfer       = (r_state == XFER);
    assign tx_src_rdy_n = w_xfer ? (r_hdr_only ? 1'b0 : tlp_src_rdy_n[r_winner]) : 1'b1;
    assign w_accept     = w_xfer && !tx_src_rdy_n && !tx_dst_rdy_n;
    assign w_last       = (r_beats_left == C_BEATS_W'(1));
    assign tx_sof_n     = !(w_xfer && r_sof_pending);
    assign tx_eof_n     = !(w_xfer && w_last);
    assign tx_data      = (w_xfer && !r_hdr_only) ? tlp_data[w_wi*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_comb begin
        tlp_dst_rdy_n = '1;
        if (w_xfer) begin
            tlp_dst_rdy_n[r_winner] = tx_dst_rdy_n;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_state          <= IDLE;
            r_grant          <= '0;
            r_winner         <= '0;
            // Previous winner = last master, so master 0 is searched first
            r_last_winner    <= IDX_W'(NUMB_MASTER - 1);
            r_beats_left     <= '0;
            r_sof_pending    <= 1'b0;
            r_hdr_only       <= 1'b0;
            r_fmt_type       <= '0;
            r_length_in_dw   <= '0;
            r_address        <= '0;
            r_ldwbe_fdwbe    <= '0;
            r_attr           <= '0;
            r_transaction_id <= '0;
            r_byte_count     <= '0;
            r_lower_address  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cfg_bus_mast_en && w_any_req) begin
                        r_grant  <= w_pick_onehot;
                        r_winner <= w_pick_idx;
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    r_fmt_type       <= w_sel_fmt;
                    r_length_in_dw   <= w_sel_len;
                    r_address        <= tlp_address[w_wi*C_ADDR_W +: C_ADDR_W];
                    r_ldwbe_fdwbe    <= tlp_ldwbe_fdwbe[w_wi*C_BE_W +: C_BE_W];
                    r_attr           <= tlp_attr[w_wi*C_ATTR_W +: C_ATTR_W];
                    r_transaction_id <= tlp_transaction_id[w_wi*C_TID_W +: C_TID_W];
                    r_byte_count     <= tlp_byte_count[w_wi*C_BC_W +: C_BC_W];
                    r_lower_address  <= tlp_lower_address[w_wi*C_LADDR_W +: C_LADDR_W];
                    r_beats_left     <= len_to_beats(w_sel_fmt, w_sel_len);
                    r_hdr_only       <= !w_sel_fmt[6];
                    r_sof_pending    <= 1'b1;
                    r_state          <= XFER;
                end
                XFER: begin
                    if (w_accept) begin
                        r_beats_left  <= r_beats_left - C_BEATS_W'(1);
                        r_sof_pending <= 1'b0;
                        if (w_last) begin
                            r_grant       <= '0;
                            r_last_winner <= r_winner;
                            r_state       <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tlp_grant         = r_grant;
    assign tx_fmt_type       = r_fmt_type;
    assign tx_length_in_dw   = r_length_in_dw;
    assign tx_address        = r_address;
    assign tx_ldwbe_fdwbe    = r_ldwbe_fdwbe;
    assign tx_attr           = r_attr;
    assign tx_transaction_id = r_transaction_id;
    assign tx_byte_count     = r_byte_count;
    assign tx_lower_address  = r_lower_address;

`ifdef TLP_TX_ARBITER_STATS_EN
    for (genvar m = 0; m < NUMB_MASTER; m++) begin : g_stat
        logic [31:0] r_pkt_cnt;
        always_ff @(posedge axi_clk or negedge axi_reset_n) begin
            if (!axi_reset_n) begin
                r_pkt_cnt <= '0;
            end else if (w_accept && w_last && (r_winner == IDX_W'(m))) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
        assign stat_pkt_cnt[m*32 +: 32] = r_pkt_cnt;
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlp_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tlp_tx_arbiter
// Description : Scoreboard bench for tlp_tx_arbiter. Each issued TLP pushes
//               its expected beats; a negedge monitor pops one entry per
//               accepted beat and compares data, framing, grant and header.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlp_tx_arbiter;

    localparam int N = 2;

    logic            axi_clk = 1'b0;
    logic            axi_reset_n;
    logic            cfg_bus_mast_en;
    logic [N-1:0]    tlp_req_to_send;
    logic [N-1:0]    tlp_grant;
    logic [N*7-1:0]  tlp_fmt_type;
    logic [N*10-1:0] tlp_length_in_dw;
    logic [N-1:0]    tlp_src_rdy_n;
    logic [N-1:0]    tlp_dst_rdy_n;
    logic [N*64-1:0] tlp_data;
    logic [N*64-1:0] tlp_address;
    logic [N*8-1:0]  tlp_ldwbe_fdwbe;
    logic [N*2-1:0]  tlp_attr;
    logic [N*24-1:0] tlp_transaction_id;
    logic [N*13-1:0] tlp_byte_count;
    logic [N*7-1:0]  tlp_lower_address;
    logic [6:0]      tx_fmt_type;
    logic [9:0]      tx_length_in_dw;
    logic [63:0]     tx_address;
    logic [7:0]      tx_ldwbe_fdwbe;
    logic [1:0]      tx_attr;
    logic [23:0]     tx_transaction_id;
    logic [12:0]     tx_byte_count;
    logic [6:0]      tx_lower_address;
    logic [63:0]     tx_data;
    logic            tx_sof_n;
    logic            tx_eof_n;
    logic            tx_src_rdy_n;
    logic            tx_dst_rdy_n;
`ifdef TLP_TX_ARBITER_STATS_EN
    logic [N*32-1:0] stat_pkt_cnt;
`endif

    always #5 axi_clk = ~axi_clk;

    tlp_tx_arbiter #(.NUMB_MASTER(N), .DATA_WIDTH(64)) dut (
        .axi_clk            (axi_clk),
        .axi_reset_n        (axi_reset_n),
        .cfg_bus_mast_en    (cfg_bus_mast_en),
        .tlp_req_to_send    (tlp_req_to_send),
        .tlp_grant          (tlp_grant),
        .tlp_fmt_type       (tlp_fmt_type),
        .tlp_length_in_dw   (tlp_length_in_dw),
        .tlp_src_rdy_n      (tlp_src_rdy_n),
        .tlp_dst_rdy_n      (tlp_dst_rdy_n),
        .tlp_data           (tlp_data),
        .tlp_address        (tlp_address),
        .tlp_ldwbe_fdwbe    (tlp_ldwbe_fdwbe),
        .tlp_attr           (tlp_attr),
        .tlp_transaction_id (tlp_transaction_id),
        .tlp_byte_count     (tlp_byte_count),
        .tlp_lower_address  (tlp_lower_address),
        .tx_fmt_type        (tx_fmt_type),
        .tx_length_in_dw    (tx_length_in_dw),
        .tx_address         (tx_address),
        .tx_ldwbe_fdwbe     (tx_ldwbe_fdwbe),
        .tx_attr            (tx_attr),
        .tx_transaction_id  (tx_transaction_id),
        .tx_byte_count      (tx_byte_count),
        .tx_lower_address   (tx_lower_address),
        .tx_data            (tx_data),
        .tx_sof_n           (tx_sof_n),
        .tx_eof_n           (tx_eof_n),
        .tx_src_rdy_n       (tx_src_rdy_n),
        .tx_dst_rdy_n       (tx_dst_rdy_n)
`ifdef TLP_TX_ARBITER_STATS_EN
        ,
        .stat_pkt_cnt       (stat_pkt_cnt)
`endif
    );

    // ---------------- master models ----------------
    int          issued  [N];   // TLPs requested (stimulus)
    int          gcnt    [N];   // grants observed (monitor)
    int          exp_seq [N];   // TLPs pushed to scoreboard
    logic [31:0] beat    [N];   // beat index inside the current TLP
    logic [6:0]  m_fmt   [N];
    logic [9:0]  m_len   [N];
    logic        src_stall;
    logic        stall_mode;

    for (genvar m = 0; m < N; m++) begin : g_m
        assign tlp_req_to_send[m]           = (issued[m] > gcnt[m]);
        assign tlp_fmt_type[m*7 +: 7]       = m_fmt[m];
        assign tlp_length_in_dw[m*10 +: 10] = m_len[m];
        assign tlp_transaction_id[m*24 +: 24] = {8'(m), 16'(gcnt[m])};
        assign tlp_data[m*64 +: 64]         = {8'(m), 24'(gcnt[m]), beat[m]};
        assign tlp_address[m*64 +: 64]      = 64'h1000 * (m + 1);
        assign tlp_ldwbe_fdwbe[m*8 +: 8]    = 8'hFF;
        assign tlp_attr[m*2 +: 2]           = 2'(m);
        assign tlp_byte_count[m*13 +: 13]   = 13'(16 + m);
        assign tlp_lower_address[m*7 +: 7]  = 7'(4 * m);
        assign tlp_src_rdy_n[m]             = src_stall;
    end

    // Flow-control driver: inputs change 1ns after the active edge
    always @(posedge axi_clk) begin
        #1;
        if (stall_mode) begin
            src_stall    = ($urandom_range(0, 3) == 0);
            tx_dst_rdy_n = ($urandom_range(0, 2) == 0);
        end else begin
            src_stall    = 1'b0;
            tx_dst_rdy_n = 1'b0;
        end
    end

    always @(posedge axi_clk or negedge axi_reset_n) begin
        for (int m = 0; m < N; m++) begin
            if (!axi_reset_n) begin
                beat[m] <= '0;
            end else if (!tx_src_rdy_n && !tx_dst_rdy_n && tlp_grant[m]) begin
                beat[m] <= tx_eof_n ? beat[m] + 32'd1 : 32'd0;
            end
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        logic [63:0] mask;
        logic        sof;
        logic        eof;
        logic [N-1:0] gnt;
        logic [9:0]  len;
        logic [23:0] tid;
    } beat_t;

    beat_t  sb[$];
    int     beats_seen = 0;
    logic   chk_gnt_low = 1'b0;
    logic [N-1:0] prev_gnt = '0;

    task automatic push_tlp(input int m, input logic [6:0] fmt, input logic [9:0] len);
        int    nb;
        beat_t e;
        exp_seq[m]++;
        m_fmt[m] = fmt;
        m_len[m] = len;
        nb = !fmt[6] ? 1 : (len == 10'd0) ? 512 : (int'(len) + 1) / 2;
        for (int b = 0; b < nb; b++) begin
            e.data = fmt[6] ? {8'(m), 24'(exp_seq[m]), 32'(b)} : 64'h0;
            e.mask = (fmt[6] && len[0] && b == nb - 1) ? 64'h0000_0000_FFFF_FFFF : '1;
            e.sof  = (b == 0);
            e.eof  = (b == nb - 1);
            e.gnt  = N'(1 << m);
            e.len  = len;
            e.tid  = {8'(m), 16'(exp_seq[m])};
            sb.push_back(e);
        end
        issued[m]++;
    endtask

    always @(negedge axi_clk) begin
        beat_t e;
        if (axi_reset_n) begin
            if (chk_gnt_low) begin
                check("grant_after_eof", 64'(tlp_grant), 64'd0);
                chk_gnt_low = 1'b0;
            end
            for (int m = 0; m < N; m++) begin
                if (tlp_grant[m] && !prev_gnt[m]) gcnt[m]++;
            end
            if (!tx_src_rdy_n && !tx_dst_rdy_n) begin
                check("beat_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("data", tx_data & e.mask, e.data & e.mask);
                    check("sof", 64'(tx_sof_n), 64'(!e.sof));
                    check("eof", 64'(tx_eof_n), 64'(!e.eof));
                    check("grant", 64'(tlp_grant), 64'(e.gnt));
                    check("tid", 64'(tx_transaction_id), 64'(e.tid));
                    check("len", 64'(tx_length_in_dw), 64'(e.len));
                    beats_seen++;
                    if (!tx_eof_n) chk_gnt_low = 1'b1;
                end
            end
        end
        prev_gnt = tlp_grant;
    end

    task automatic wait_drain(input string tag, input int budget);
        int c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(negedge axi_clk);
            c++;
        end
        repeat (2) @(negedge axi_clk);
        check({"drain_", tag}, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_grant"},  64'(tlp_grant), 64'd0);
        check({tag, "_dstrdy"}, 64'(tlp_dst_rdy_n), 64'(2'b11));
        check({tag, "_srcrdy"}, 64'(tx_src_rdy_n), 64'd1);
        check({tag, "_sof"},    64'(tx_sof_n), 64'd1);
        check({tag, "_eof"},    64'(tx_eof_n), 64'd1);
        check({tag, "_data"},   tx_data, 64'd0);
        check({tag, "_len"},    64'(tx_length_in_dw), 64'd0);
        check({tag, "_tid"},    64'(tx_transaction_id), 64'd0);
        check({tag, "_addr"},   tx_address, 64'd0);
    endtask

    task automatic do_reset();
        axi_reset_n = 1'b0;
        sb.delete();
        repeat (3) @(posedge axi_clk);
        #2 axi_reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int c;
        axi_reset_n     = 1'b0;
        cfg_bus_mast_en = 1'b0;
        stall_mode      = 1'b0;
        src_stall       = 1'b0;
        tx_dst_rdy_n    = 1'b0;
        for (int m = 0; m < N; m++) begin
            issued[m] = 0; gcnt[m] = 0; exp_seq[m] = 0;
            m_fmt[m] = 7'h60; m_len[m] = 10'd1;
        end

        do_reset();
        check_reset_vals("rst");
        @(negedge axi_clk);
        cfg_bus_mast_en = 1'b1;

        // Single 32-DW write from master 0: 16 beats
        push_tlp(0, 7'h60, 10'h20);
        wait_drain("mwr16", 200);

        // Both masters continuously requesting: grants alternate 0,1,0,1...
        do_reset();
        @(negedge axi_clk);
        cfg_bus_mast_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_tlp(0, 7'h60, 10'd4);
            push_tlp(1, 7'h60, 10'd4);
        end
        wait_drain("rr", 200);

        // Odd length: 3 DW -> 2 beats
        push_tlp(1, 7'h60, 10'd3);
        wait_drain("odd", 50);

        // 1024 DW under random stalls: exactly 512 beats
        base = beats_seen;
        stall_mode = 1'b1;
        push_tlp(0, 7'h60, 10'd0);
        wait_drain("len1024", 6000);
        check("beats_1024", 64'(beats_seen - base), 64'd512);
        stall_mode = 1'b0;
        repeat (2) @(negedge axi_clk);

        // Header-only read: single beat, SOF+EOF, zero data
        push_tlp(1, 7'h20, 10'd1);
        wait_drain("hdr_only", 50);

        // Bus mastering disabled: request pending but no grant
        cfg_bus_mast_en = 1'b0;
        push_tlp(0, 7'h60, 10'h20);
        repeat (10) @(negedge axi_clk);
        check("no_grant_disabled", 64'(tlp_grant), 64'd0);
        cfg_bus_mast_en = 1'b1;
        c = 0;
        while (tlp_grant == '0 && c < 10) begin
            @(negedge axi_clk);
            c++;
        end
        check("grant_latency_ok", 64'(c <= 2), 64'd1);
        check("grant_master0", 64'(tlp_grant), 64'(2'b01));

        // Reset in the middle of that TLP
        base = beats_seen;
        c = 0;
        while (beats_seen < base + 3 && c < 100) begin
            @(negedge axi_clk);
            c++;
        end
        check("midtlp_beats", 64'(beats_seen >= base + 3), 64'd1);
        @(posedge axi_clk);
        #1 axi_reset_n = 1'b0;
        sb.delete();
        #1 check_reset_vals("midrst");
        repeat (2) @(posedge axi_clk);
        #2 axi_reset_n = 1'b1;
        repeat (4) @(negedge axi_clk);
        check("idle_after_rst", 64'(tlp_grant), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
